// File: rtl/adder_sched_if.sv
// adder_sched_if -- handshake bundle for the shared adder scheduler.
//   req0_*/req1_* : two requesters (valid/ready, a/b operand words, sub, last)
//   rsp_*         : single result stream (valid/ready, sum, id, last, cout)
// master = requesters + result consumer, slave = the scheduler.
interface adder_sched_if #(parameter int W = 64);
    logic         req0_valid, req0_ready, req0_sub, req0_last;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready, req1_sub, req1_last;
    logic [W-1:0] req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_last, rsp_cout;
    logic [W-1:0] rsp_sum;

    modport master (
        output req0_valid, req0_sub, req0_last, req0_a, req0_b,
        output req1_valid, req1_sub, req1_last, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_last, rsp_cout, rsp_sum
    );

    modport slave (
        input  req0_valid, req0_sub, req0_last, req0_a, req0_b,
        input  req1_valid, req1_sub, req1_last, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_last, rsp_cout, rsp_sum
    );
endinterface

// File: rtl/adder_sched.sv
// adder_sched -- two requesters share one W-bit adder for multi-word add/sub.
// A multi-word transaction locks the adder to its owner until its last word;
// ties in IDLE are broken round-robin. One-cycle registered result.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : adder_sched_if.slave (requests in, results out)
//   busy       : high while a transaction holds the lock
module adder_sched #(
    parameter int W = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    adder_sched_if.slave  bus,
    output logic          busy
);
    typedef enum logic { IDLE, LOCK } state_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic         last;
    } req_t;

    state_t state, state_n;
    logic   owner, owner_n, last_grant, last_grant_n;
    logic   carry, carry_n, sub_q, sub_n;

    req_t         r0, r1, rs;
    logic         winner, sel, out_free, acc, sub_eff, cin, cout;
    logic [W-1:0] sum;

    always_comb begin
        r0 = '{a: bus.req0_a, b: bus.req0_b, sub: bus.req0_sub, last: bus.req0_last};
        r1 = '{a: bus.req1_a, b: bus.req1_b, sub: bus.req1_sub, last: bus.req1_last};
    end

    // Round-robin only matters on a tie; a lone requester always wins.
    always_comb begin
        winner = 1'b0;
        if (bus.req0_valid && bus.req1_valid) winner = ~last_grant;
        else if (bus.req1_valid)              winner = 1'b1;
    end

    assign out_free       = !bus.rsp_valid || bus.rsp_ready;
    assign bus.req0_ready = out_free && ((state == IDLE) ? (!winner && bus.req0_valid) : !owner);
    assign bus.req1_ready = out_free && ((state == IDLE) ? ( winner && bus.req1_valid) :  owner);

    assign sel = (state == IDLE) ? winner : owner;
    assign rs  = sel ? r1 : r0;
    assign acc = sel ? (bus.req1_valid && bus.req1_ready) : (bus.req0_valid && bus.req0_ready);

    // First word takes sub from the request and seeds cin with it (two's
    // complement +1); later words use the latched sub and the chained carry.
    assign sub_eff = (state == IDLE) ? rs.sub : sub_q;
    assign cin     = (state == IDLE) ? rs.sub : carry;
    assign {cout, sum} = {1'b0, rs.a} + {1'b0, (sub_eff ? ~rs.b : rs.b)} + {{W{1'b0}}, cin};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            carry      <= 1'b0;
            sub_q      <= 1'b0;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            last_grant <= last_grant_n;
            carry      <= carry_n;
            sub_q      <= sub_n;
        end
    end

    always_comb begin
        state_n      = state;
        owner_n      = owner;
        last_grant_n = last_grant;
        carry_n      = carry;
        sub_n        = sub_q;
        if (acc) begin
            if (rs.last) begin
                state_n      = IDLE;
                last_grant_n = sel;
                carry_n      = 1'b0;
            end else begin
                state_n = LOCK;
                carry_n = cout;
                if (state == IDLE) begin
                    owner_n = sel;
                    sub_n   = rs.sub;
                end
            end
        end
    end

    // Single-entry output register; a new accept overwrites a draining entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_sum   <= '0;
            bus.rsp_id    <= 1'b0;
            bus.rsp_last  <= 1'b0;
            bus.rsp_cout  <= 1'b0;
        end else if (acc) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_sum   <= sum;
            bus.rsp_id    <= sel;
            bus.rsp_last  <= rs.last;
            bus.rsp_cout  <= cout;
        end else if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
        end
    end

    assign busy = (state == LOCK);
endmodule

// File: tb/tb_adder_sched.sv
module tb_adder_sched;
    localparam int W    = 64;
    localparam int MAXN = 3;
    typedef logic [W*MAXN:0] big_t;
    typedef struct { logic [W-1:0] sum; logic cout; logic last; } exp_t;
    typedef struct { logic id; logic sub; logic [W-1:0] a, b, sum; logic cout; } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    adder_sched_if #(.W(W)) bus();
    adder_sched #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave), .busy(busy));

    always #5 clk = ~clk;

    int   n_vec = 0, n_err = 0;
    exp_t q0[$], q1[$];
    bit   mon_en = 1'b0;
    bit   in_txn = 1'b0;
    logic cur_id = 1'b0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out waiting for handshake", nm);
    endtask

    // Multi-word reference: treat the operand words as one big number and
    // read each result word and its carry/no-borrow straight off the arithmetic.
    function automatic void model(input logic [MAXN-1:0][W-1:0] a, input logic [MAXN-1:0][W-1:0] b,
                                  input int n, input logic sub,
                                  output logic [MAXN-1:0][W-1:0] s, output logic [MAXN-1:0] c);
        big_t ba, bb, m, la, lb, r, one;
        one = 1;
        ba  = '0;
        bb  = '0;
        s   = '0;
        c   = '0;
        for (int i = 0; i < n; i++) begin
            ba |= big_t'(a[i]) << (i*W);
            bb |= big_t'(b[i]) << (i*W);
        end
        for (int i = 0; i < n; i++) begin
            m  = (one << ((i+1)*W)) - one;
            la = ba & m;
            lb = bb & m;
            r  = sub ? la - lb : la + lb;
            s[i] = r[i*W +: W];
            c[i] = sub ? (la >= lb) : r[(i+1)*W];
        end
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            2:       return 1;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    function automatic logic rdy(input int id);
        return id ? bus.req1_ready : bus.req0_ready;
    endfunction

    task automatic set_req(input int id, input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic sub, input logic last);
        if (id == 0) begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_sub = sub; bus.req0_last = last;
        end else begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_sub = sub; bus.req1_last = last;
        end
    endtask

    // Called just after a rising edge with the word already driven; returns
    // just after the edge that accepted it.
    task automatic wait_acc(input int id, input string nm);
        bit acc = 1'b0;
        for (int k = 0; k < 100 && !acc; k++) begin
            @(negedge clk);
            acc = rdy(id);
            @(posedge clk); #1;
        end
        if (!acc) timeout(nm);
    endtask

    task automatic send(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic last);
        @(posedge clk); #1;
        set_req(id, 1'b1, a, b, sub, last);
        wait_acc(id, "send_accept");
        set_req(id, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic drv(input int id, input int ntx);
        logic [MAXN-1:0][W-1:0] a, b, s;
        logic [MAXN-1:0]        c;
        int   n;
        logic sub;
        exp_t e;
        for (int t = 0; t < ntx; t++) begin
            n   = $urandom_range(1, MAXN);
            sub = 1'($urandom_range(0, 1));
            for (int i = 0; i < MAXN; i++) begin
                a[i] = pick();
                b[i] = pick();
            end
            model(a, b, n, sub, s, c);
            for (int i = 0; i < n; i++) begin
                e = '{sum: s[i], cout: c[i], last: (i == n-1)};
                if (id == 0) q0.push_back(e); else q1.push_back(e);
            end
            for (int i = 0; i < n; i++) begin
                // sub on non-first words is noise the design must ignore
                set_req(id, 1'b1, a[i], b[i], (i == 0) ? sub : 1'($urandom_range(0, 1)), (i == n-1));
                wait_acc(id, "rand_accept");
            end
            set_req(id, 1'b0, '0, '0, 1'b0, 1'b0);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
    endtask

    // Scoreboard: every consumed result is matched against its requester's queue.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (mon_en && bus.rsp_valid && bus.rsp_ready) begin
            if (in_txn) chk("no_interleave", W'(bus.rsp_id), W'(cur_id));
            in_txn = !bus.rsp_last;
            cur_id = bus.rsp_id;
            if ((bus.rsp_id ? q1.size() : q0.size()) == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rsp_unexpected: id %0d sum %h, required no response", bus.rsp_id, bus.rsp_sum);
            end else begin
                e = bus.rsp_id ? q1.pop_front() : q0.pop_front();
                chk("rand_sum",  bus.rsp_sum, e.sum);
                chk("rand_cout", W'(bus.rsp_cout), W'(e.cout));
                chk("rand_last", W'(bus.rsp_last), W'(e.last));
            end
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (mon_en) bus.rsp_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        vec_t vt[8];
        logic [MAXN-1:0][W-1:0] a0, b0, a1, b1;
        logic [W-1:0] es[6];
        logic         ec[6], ei[6];
        int  i0, i1, k;
        bit  acc0, acc1;

        set_req(0, 1'b0, '0, '0, 1'b0, 1'b0);
        set_req(1, 1'b0, '0, '0, 1'b0, 1'b0);
        bus.rsp_ready = 1'b1;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", W'(bus.rsp_valid), 0);
        chk("rst_rsp_sum",   bus.rsp_sum, 0);
        chk("rst_rsp_id",    W'(bus.rsp_id), 0);
        chk("rst_rsp_last",  W'(bus.rsp_last), 0);
        chk("rst_rsp_cout",  W'(bus.rsp_cout), 0);
        chk("rst_busy",      W'(busy), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // single-word table
        vt[0] = '{1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1};
        vt[1] = '{1'b0, 1'b1, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
        vt[2] = '{1'b1, 1'b0, 64'd2, 64'd3, 64'd5, 1'b0};
        vt[3] = '{1'b1, 1'b1, 64'd7, 64'd7, 64'd0, 1'b1};
        vt[4] = '{1'b0, 1'b1, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vt[5] = '{1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 1'b1};
        vt[6] = '{1'b0, 1'b1, 64'd0, 64'd0, 64'd0, 1'b1};
        vt[7] = '{1'b1, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 64'h2222_2222_2222_2211, 1'b0};
        for (int i = 0; i < 8; i++) begin
            send(int'(vt[i].id), vt[i].a, vt[i].b, vt[i].sub, 1'b1);
            @(negedge clk);
            chk("tbl_valid", W'(bus.rsp_valid), 1);
            chk("tbl_sum",   bus.rsp_sum, vt[i].sum);
            chk("tbl_cout",  W'(bus.rsp_cout), W'(vt[i].cout));
            chk("tbl_id",    W'(bus.rsp_id), W'(vt[i].id));
            chk("tbl_last",  W'(bus.rsp_last), 1);
            chk("tbl_busy",  W'(busy), 0);
        end

        // req1 two-word carry chain
        send(1, '1, 64'd1, 1'b0, 1'b0);
        @(negedge clk);
        chk("two_w0_sum",  bus.rsp_sum, 0);
        chk("two_w0_cout", W'(bus.rsp_cout), 1);
        chk("two_w0_last", W'(bus.rsp_last), 0);
        chk("two_w0_id",   W'(bus.rsp_id), 1);
        chk("two_busy",    W'(busy), 1);
        send(1, '0, '0, 1'b0, 1'b1);
        @(negedge clk);
        chk("two_w1_sum",  bus.rsp_sum, 1);
        chk("two_w1_cout", W'(bus.rsp_cout), 0);
        chk("two_w1_last", W'(bus.rsp_last), 1);
        chk("two_idle",    W'(busy), 0);

        // both requesters with 3-word transactions from reset
        do_reset();
        a0[0] = '1; a0[1] = '1; a0[2] = 64'd5;  b0[0] = 64'd1; b0[1] = '0; b0[2] = '0;
        a1[0] = '0; a1[1] = '0; a1[2] = 64'd9;  b1[0] = 64'd1; b1[1] = '0; b1[2] = '0;
        es[0] = '0; es[1] = '0; es[2] = 64'd6;  ec[0] = 1; ec[1] = 1; ec[2] = 0;
        es[3] = '1; es[4] = '1; es[5] = 64'd8;  ec[3] = 0; ec[4] = 0; ec[5] = 1;
        for (int i = 0; i < 6; i++) ei[i] = (i >= 3);
        i0 = 0; i1 = 0; k = 0;
        set_req(0, 1'b1, a0[0], b0[0], 1'b0, 1'b0);
        set_req(1, 1'b1, a1[0], b1[0], 1'b1, 1'b0);
        for (int cyc = 0; cyc < 40 && k < 6; cyc++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                chk("rr_sum",  bus.rsp_sum, es[k]);
                chk("rr_cout", W'(bus.rsp_cout), W'(ec[k]));
                chk("rr_id",   W'(bus.rsp_id), W'(ei[k]));
                chk("rr_last", W'(bus.rsp_last), W'(k == 2 || k == 5));
                k++;
            end
            if (i0 < 3) chk("rr_req1_held", W'(bus.req1_ready), 0);
            acc0 = bus.req0_valid && bus.req0_ready;
            acc1 = bus.req1_valid && bus.req1_ready;
            @(posedge clk); #1;
            if (acc0) i0++;
            if (acc1) i1++;
            set_req(0, i0 < 3, (i0 < 3) ? a0[i0] : '0, (i0 < 3) ? b0[i0] : '0, 1'b0, i0 == 2);
            set_req(1, i1 < 3, (i1 < 3) ? a1[i1] : '0, (i1 < 3) ? b1[i1] : '0, 1'b1, i1 == 2);
        end
        chk("rr_all_words", W'(k), 6);
        // tie after req1 finished goes to req0
        set_req(0, 1'b1, 64'd5, 64'd1, 1'b0, 1'b1);
        set_req(1, 1'b1, 64'd9, 64'd1, 1'b0, 1'b1);
        @(negedge clk);
        chk("tie_req0_ready", W'(bus.req0_ready), 1);
        chk("tie_req1_ready", W'(bus.req1_ready), 0);
        @(posedge clk); #1;
        set_req(0, 1'b0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        chk("tie_rsp0_id",  W'(bus.rsp_id), 0);
        chk("tie_rsp0_sum", bus.rsp_sum, 6);
        chk("tie_req1_next", W'(bus.req1_ready), 1);
        @(posedge clk); #1;
        set_req(1, 1'b0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        chk("tie_rsp1_id",  W'(bus.rsp_id), 1);
        chk("tie_rsp1_sum", bus.rsp_sum, 10);

        // output backpressure for 3 cycles, then full throughput
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        set_req(0, 1'b1, '1, 64'd1, 1'b0, 1'b0);
        @(negedge clk);
        chk("stall_first_ready", W'(bus.req0_ready), 1);
        @(posedge clk); #1;
        set_req(0, 1'b1, 64'd2, 64'd3, 1'b0, 1'b0);
        set_req(1, 1'b1, 64'd1, 64'd1, 1'b0, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("stall_valid",  W'(bus.rsp_valid), 1);
            chk("stall_sum",    bus.rsp_sum, 0);
            chk("stall_cout",   W'(bus.rsp_cout), 1);
            chk("stall_last",   W'(bus.rsp_last), 0);
            chk("stall_ready0", W'(bus.req0_ready), 0);
            chk("stall_ready1", W'(bus.req1_ready), 0);
            @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
        set_req(1, 1'b0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        chk("release_ready0", W'(bus.req0_ready), 1);
        @(posedge clk); #1;
        set_req(0, 1'b1, 64'd7, 64'd0, 1'b0, 1'b1);
        @(negedge clk);
        chk("tput_w1_valid", W'(bus.rsp_valid), 1);
        chk("tput_w1_sum",   bus.rsp_sum, 6);
        chk("tput_w2_ready", W'(bus.req0_ready), 1);
        @(posedge clk); #1;
        set_req(0, 1'b0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        chk("tput_w2_sum",  bus.rsp_sum, 7);
        chk("tput_w2_last", W'(bus.rsp_last), 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("drain_valid_low", W'(bus.rsp_valid), 0);

        // reset in the middle of a req1 transaction
        send(1, '1, 64'd1, 1'b0, 1'b0);
        @(negedge clk);
        chk("midrst_busy_before", W'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", W'(bus.rsp_valid), 0);
        chk("midrst_sum",   bus.rsp_sum, 0);
        chk("midrst_id",    W'(bus.rsp_id), 0);
        chk("midrst_last",  W'(bus.rsp_last), 0);
        chk("midrst_cout",  W'(bus.rsp_cout), 0);
        chk("midrst_busy",  W'(busy), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(0, 64'd5, 64'd6, 1'b0, 1'b1);
        @(negedge clk);
        chk("postrst_sum",  bus.rsp_sum, 11);
        chk("postrst_cout", W'(bus.rsp_cout), 0);
        chk("postrst_id",   W'(bus.rsp_id), 0);

        // randomized traffic against the big-number model
        do_reset();
        in_txn = 1'b0;
        mon_en = 1'b1;
        fork
            drv(0, 25);
            drv(1, 25);
        join
        for (int c = 0; c < 200 && (q0.size() != 0 || q1.size() != 0); c++) @(posedge clk);
        @(negedge clk);
        chk("rand_q0_drained", W'(q0.size()), 0);
        chk("rand_q1_drained", W'(q1.size()), 0);
        mon_en = 1'b0;
        bus.rsp_ready = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/adder_sched.md
ADDER_SCHED -- requirements
Module: adder_sched

Interface
REQ-001 SHALL have parameter W, default 64, datapath word width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester word present.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1  word accepted this cycle when valid&ready.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  W  operand words, least-significant word first.
REQ-007 SHALL have ports req0_sub / req1_sub  input  1  1 = a-b, 0 = a+b; sampled on first word of a transaction only.
REQ-008 SHALL have ports req0_last / req1_last  input  1  final word of the transaction.
REQ-009 SHALL have port rsp_valid  output  1  result word present.
REQ-010 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-011 SHALL have ports rsp_sum  output  W, rsp_id  output  1 (owning requester), rsp_last  output  1, rsp_cout  output  1 (carry out of this word; 0 = borrow when subtracting).
REQ-012 SHALL have port busy  output  1  high while a transaction is locked.

Function
REQ-013 SHALL contain one shared W-bit adder computing a + (sub ? ~b : b) + cin, with cout the carry out of bit W-1.
REQ-014 SHALL use cin = sub on the first word of a transaction and cin = stored carry of the previous word otherwise.
REQ-015 SHALL implement FSM states IDLE and LOCK; owner register (1 bit), last_grant register (1 bit), carry register, sub register.
REQ-016 In IDLE, winner SHALL be the only valid requester, or if both valid, the requester != last_grant (round-robin).
REQ-017 out_free SHALL be !rsp_valid | rsp_ready.
REQ-018 reqN_ready SHALL be out_free & (IDLE ? winner==N & reqN_valid : owner==N); the non-owner's ready SHALL be 0 in LOCK.
REQ-019 On an accepted word with last=0: IDLE->LOCK, owner=winner, sub latched, carry=cout; in LOCK stay, carry=cout.
REQ-020 On an accepted word with last=1: go/stay IDLE, last_grant=owner of that word, carry cleared.
REQ-021 A single-word transaction (last=1 on first word) SHALL complete entirely in IDLE.
REQ-022 Latency SHALL be exactly 1 cycle: accepted word at edge k -> rsp_valid with rsp_sum/rsp_id/rsp_last/rsp_cout after edge k.
REQ-023 Output register SHALL be single-entry; while rsp_valid & !rsp_ready all rsp_* SHALL hold stable and no word SHALL be accepted.
REQ-024 Simultaneous drain and accept (rsp_ready=1, new word accepted) SHALL replace the output with no bubble.
REQ-025 With no word accepted and rsp_ready=1, rsp_valid SHALL fall next cycle.
REQ-026 Transactions SHALL never interleave; other requester waits until owner's last word is accepted.
REQ-027 busy SHALL equal (state==LOCK).
REQ-028 Wrap-around: sum SHALL be modulo 2^W; carry chain length SHALL be unlimited.

Reset
REQ-029 On rst_n low, immediately: state=IDLE, owner=0, last_grant=1 (req0 wins first tie), carry=0, sub=0, rsp_valid=0, rsp_sum=0, rsp_id=0, rsp_last=0, rsp_cout=0, busy=0.
REQ-030 Reset mid-transaction SHALL discard the lock and pending result; first post-reset word SHALL start a new transaction.

Verification
REQ-031 req0 add, a=FFFF_FFFF_FFFF_FFFF, b=1, last=1 -> next cycle rsp_sum=0, rsp_cout=1, rsp_id=0, rsp_last=1.
REQ-032 req1 two-word add, {a=all-ones,b=1,last=0},{a=0,b=0,last=1} -> rsp words 0 (cout=1) then 1 (cout=0, last=1), busy high between.
REQ-033 req0 subtract a=5, b=7, last=1 -> rsp_sum=FFFF_FFFF_FFFF_FFFE, rsp_cout=0.
REQ-034 Both valid from reset, each a 3-word transaction -> all 3 req0 words, then all 3 req1 words, req1_ready=0 throughout req0 lock; a following tie goes to req0.
REQ-035 rsp_ready held 0 for 3 cycles with rsp_valid=1 -> rsp_* unchanged, both ready=0, no word lost; full throughput resumes on release.
REQ-036 rst_n pulsed low after word 1 of a 3-word req1 transaction -> all outputs 0, busy=0; fresh req0 single word returns correct sum with cin=0.
